// File: rtl/shift_32_ctrl_pkg.sv
// Shared definitions for the shift_32 command sequencer.
// Op codes, shifter mode codes, controller state codes and a legality helper.
package shift_32_ctrl_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // S1S0 encodings of the 194-style register
  typedef enum logic [1:0] {
    M_HOLD = 2'b00,
    M_SHR  = 2'b01,  // toward bit 0, SR fills bit 31
    M_SHL  = 2'b10,  // toward bit 31, SL fills bit 0
    M_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/shift_32_ctrl_shift32.sv
// shift_32: 32-bit 194-style universal shift register (datapath).
// Ports:
//   clk    rising-edge clock
//   clear  synchronous active-high clear, Q <= 0
//   s      S1S0 mode: 00 hold, 01 shift toward bit 0, 10 shift toward bit 31, 11 load
//   sl     serial fill for bit 0 on left shift
//   sr     serial fill for bit 31 on right shift
//   pdata  parallel load data
//   q      register contents
module shift_32
  import shift_32_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic [1:0]  s,
  input  logic        sl,
  input  logic        sr,
  input  logic [31:0] pdata,
  output logic [31:0] q
);

  logic [31:0] q_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      q_q <= '0;
    end else begin
      case (s)
        M_SHR:   q_q <= {sr, q_q[31:1]};
        M_SHL:   q_q <= {q_q[30:0], sl};
        M_LOAD:  q_q <= pdata;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_32_ctrl.sv
// shift_32_ctrl: command sequencer around shift_32.
// Takes one (op, count, data) command per transaction, loads the word, runs
// count single-bit shifts, and presents the result until it is taken.
// Ports:
//   clk, clear             clock, synchronous active-high reset (also clears shift_32)
//   cmd_valid/cmd_ready    command handshake; ready only in IDLE
//   cmd_op/cmd_cnt/cmd_data  op (000 SLL..100 ROR, others illegal), shift count, word
//   res_valid/res_ready    result handshake; valid only in DONE
//   res_data/res_err       shifted word (shift_32 Q) and illegal-op flag
//   busy                   high in LOAD, SHIFT, DONE
module shift_32_ctrl
  import shift_32_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;

  mode_e            mode;
  logic             sl, sr;
  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Shifter controls depend only on registered state and Q, so there is no
  // combinational path from cmd_* into the datapath.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mode    = M_HOLD;
    sl      = 1'b0;
    sr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          cnt_d   = cmd_cnt;
          data_d  = cmd_data;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        mode    = M_LOAD;
        state_d = (cnt_q == '0 || !op_legal(op_q)) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        case (op_q)
          OP_SLL:  mode = M_SHL;
          OP_SRL:  mode = M_SHR;
          OP_SRA:  begin mode = M_SHR; sr = q[WIDTH-1]; end
          OP_ROL:  begin mode = M_SHL; sl = q[WIDTH-1]; end
          OP_ROR:  begin mode = M_SHR; sr = q[0];       end
          default: mode = M_HOLD;
        endcase
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  shift_32 u_shift (
    .clk   (clk),
    .clear (clear),
    .s     (mode),
    .sl    (sl),
    .sr    (sr),
    .pdata (data_q),
    .q     (q)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_err   = res_valid && !op_legal(op_q);
  assign busy      = (state_q != ST_IDLE);
  assign res_data  = q;

endmodule

// File: tb/tb_shift_32_ctrl.sv
// Self-checking bench for shift_32_ctrl: directed vector table, random
// commands against an arithmetic reference model, and handshake/reset corners.
module tb_shift_32_ctrl;

  logic        clk = 1'b0;
  logic        clear;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_cnt;
  logic [31:0] cmd_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_32_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .clear     (clear),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_data  (cmd_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  cnt;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: shifts by plain arithmetic on the whole word.
  function automatic logic [31:0] model(input logic [2:0] op, input int n, input logic [31:0] d);
    logic [31:0] r;
    case (op)
      3'd0: r = d << n;
      3'd1: r = d >> n;
      3'd2: r = 32'($signed(d) >>> n);
      3'd3: r = (n == 0) ? d : ((d << n) | (d >> (32 - n)));
      3'd4: r = (n == 0) ? d : ((d >> n) | (d << (32 - n)));
      default: r = d;
    endcase
    return r;
  endfunction

  // Issue a command, wait for the result, retire it. Latency is counted in
  // cycles from the accepting edge to res_valid high.
  task automatic run_cmd(input logic [2:0] op, input logic [4:0] cnt, input logic [31:0] data,
                         output logic [31:0] got, output logic err, output int lat);
    int w;
    cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 100) begin step(); w++; end
    if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 100) begin step(); lat++; end
    got = res_data;
    err = res_err;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    logic [31:0] got, held, expd;
    logic        err;
    int          lat;
    logic [2:0]  rop;
    logic [4:0]  rcnt;
    logic [31:0] rdata;

    vecs[0] = '{3'b000, 5'd4,  32'h0000_0001, 32'h0000_0010, 1'b0, 5};
    vecs[1] = '{3'b010, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32};
    vecs[2] = '{3'b001, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0, 32};
    vecs[3] = '{3'b100, 5'd1,  32'h0000_0001, 32'h8000_0000, 1'b0, 2};
    vecs[4] = '{3'b011, 5'd4,  32'h8000_0001, 32'h0000_0018, 1'b0, 5};
    vecs[5] = '{3'b000, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1};
    vecs[6] = '{3'b100, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1};
    vecs[7] = '{3'b110, 5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1};
    vecs[8] = '{3'b101, 5'd0,  32'h1234_5678, 32'h1234_5678, 1'b1, 1};

    clear = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_op = '0; cmd_cnt = '0; cmd_data = '0;
    repeat (3) step();
    clear = 1'b0;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_err",   32'(res_err),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_q",         res_data,       32'd0);

    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].cnt, vecs[i].data, got, err, lat);
      chk($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_idle", i), 32'(cmd_ready), 32'd1);
    end

    // Result held in DONE: stable outputs, cmd_valid ignored.
    cmd_op = 3'b000; cmd_cnt = 5'd3; cmd_data = 32'h0000_00F0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 100) begin step(); lat++; end
    chk("hold_lat", 32'(lat), 32'd4);
    held = res_data;
    chk("hold_data", held, 32'h0000_0780);
    for (int c = 0; c < 3; c++) begin
      cmd_valid = (c == 1);
      cmd_op = 3'b001; cmd_cnt = 5'd1; cmd_data = 32'hFFFF_FFFF;
      step();
      chk($sformatf("hold%0d_valid", c), 32'(res_valid), 32'd1);
      chk($sformatf("hold%0d_data", c),  res_data, held);
      chk($sformatf("hold%0d_ready", c), 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("hold_ret_ready", 32'(cmd_ready), 32'd1);
    chk("hold_ret_valid", 32'(res_valid), 32'd0);
    step();
    chk("hold_no_accept", 32'(busy), 32'd0);

    // Same-cycle retire and new command: accepted only the cycle after.
    cmd_op = 3'b011; cmd_cnt = 5'd0; cmd_data = 32'hA5A5_0000; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("same_done", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    cmd_op = 3'b100; cmd_cnt = 5'd8; cmd_data = 32'h0000_00AB; cmd_valid = 1'b1;
    step();
    res_ready = 1'b0;
    chk("same_idle", 32'(busy), 32'd0);
    step();
    cmd_valid = 1'b0;
    chk("same_accept", 32'(busy), 32'd1);
    lat = 0;
    while (!res_valid && lat < 100) begin step(); lat++; end
    chk("same_lat",  32'(lat), 32'd9);
    chk("same_data", res_data, 32'hAB00_0000);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Clear mid-SHIFT discards the command.
    cmd_op = 3'b000; cmd_cnt = 5'd20; cmd_data = 32'h0000_0003; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (5) step();
    chk("clr_pre_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_ready", 32'(cmd_ready), 32'd1);
    chk("clr_valid", 32'(res_valid), 32'd0);
    chk("clr_busy",  32'(busy),      32'd0);
    chk("clr_q",     res_data,       32'd0);
    run_cmd(3'b010, 5'd3, 32'hF000_0000, got, err, lat);
    chk("post_clr_data", got, 32'hFE00_0000);
    chk("post_clr_lat",  32'(lat), 32'd4);

    // Random commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop   = 3'($urandom_range(0, 7));
      rcnt  = 5'($urandom_range(0, 31));
      rdata = $urandom;
      run_cmd(rop, rcnt, rdata, got, err, lat);
      expd = model(rop, int'(rcnt), rdata);
      chk($sformatf("rnd%0d_data op=%0d n=%0d", i, rop, rcnt), got, expd);
      chk($sformatf("rnd%0d_err", i), 32'(err), 32'(rop > 3'd4));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), (rop > 3'd4) ? 32'd1 : 32'(rcnt) + 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
